ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset.
- It is the counterpart of the existing PS/2 receive path that feeds keyboard_tracker.
- It drives both PS/2 lines open-drain through pull-low enables and follows the device-generated clock.
- It reports completion, device ACK and timeout back to the game control logic.

Parameters:
- INHIBIT_CYCLES, 6000: clk cycles the host holds PS2 clock low before requesting to send (120 us at 50 MHz).
- RTS_CYCLES, 250: clk cycles with both lines low before the clock is released (5 us).
- TIMEOUT_CYCLES, 750000: maximum clk cycles waited for any single expected device edge (15 ms).

Ports:
- clk  in  1  system clock, 50 MHz
- resetn  in  1  synchronous, active-low reset
- tx_data  in  8  byte to send
- tx_valid  in  1  request; accepted only when tx_ready=1
- tx_ready  out  1  high only in IDLE
- ps2_clk_in  in  1  raw PS2_CLK pad value (asynchronous)
- ps2_dat_in  in  1  raw PS2_DAT pad value (asynchronous)
- ps2_clk_drive_low  out  1  1 = pull PS2_CLK low, 0 = release (high-Z)
- ps2_dat_drive_low  out  1  1 = pull PS2_DAT low, 0 = release
- done  out  1  one-cycle pulse: byte sent and ACK received
- error  out  1  one-cycle pulse: NACK or timeout
- busy  out  1  high in every non-IDLE state; the receive path ignores bytes while busy=1

Behaviour:
- Reset: state IDLE; all counters and the shift register cleared. Outputs: tx_ready=1, busy=0, both drive_low=0, done=0, error=0. Reset mid-transfer releases both lines on the next clk edge; no done or error pulse is produced.
- Input sync: ps2_clk_in and ps2_dat_in each pass through 2 flops. A falling edge (fe) is synced clk 1 -> 0 between consecutive samples.
- Accept: in IDLE with tx_valid=1, latch {parity, tx_data}, where parity = ~^tx_data (odd parity). Go to INHIBIT. tx_valid in any other state is ignored and never queued.
- INHIBIT: clk_drive_low=1, dat_drive_low=0 for exactly INHIBIT_CYCLES cycles, then go to RTS.
- RTS: clk_drive_low=1, dat_drive_low=1 (start bit 0) for RTS_CYCLES cycles, then go to SEND. On entry to SEND, clk_drive_low=0 and dat_drive_low stays 1.
- SEND: bit index i runs 0..9 and advances on each fe.
  - fe #1..#8: dat_drive_low = ~tx_data[i-1], LSB first.
  - fe #9: dat_drive_low = ~parity.
  - fe #10: dat_drive_low = 0 (stop bit, line released). Go to ACK.
  - Data changes only in the clk cycle after the fe is detected. The device samples on its rising edge.
- ACK: wait for fe #11, then sample synced dat.
  - dat=0: go to WAIT_IDLE.
  - dat=1: pulse error, go to IDLE.
- WAIT_IDLE: wait until synced clk=1 and dat=1 in the same cycle, then pulse done and go to IDLE.
- Timeout: one watchdog counter, cleared on each state entry and on each fe. It counts in SEND, ACK and WAIT_IDLE. On reaching TIMEOUT_CYCLES: release both lines, pulse error, go to IDLE.
- done and error are mutually exclusive and last exactly one cycle. tx_ready rises in the cycle after the pulse.
- Counter widths: ceil(log2(max parameter+1)). Bit index 4 bits.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz and ACKing. Inhibit lasts 6000 cycles and RTS lasts 250. Line bits after fe #1..#10 are 1,0,1,1,0,1,1,1,parity=1,stop=1. Exactly one done pulse, error=0, tx_ready back to 1.
- Send 0x00: parity bit driven is 1; 0xFF: parity bit driven is 1; 0x01: parity bit driven is 0. Each transfer ends in done.
- Device holds dat=1 at fe #11 (NACK): error pulses once, no done, both drive_low=0, state IDLE.
- Device never clocks after RTS: error pulses exactly TIMEOUT_CYCLES cycles after entering SEND, and both lines are released.
- Assert resetn=0 after fe #5: one clk later both drive_low=0, tx_ready=1, busy=0, no done/error pulse. A new 0xF4 send afterwards completes correctly.
- Pulse tx_valid with 0xAA during an active 0xED transfer: the second byte is never transmitted, exactly one done, and the line shows only the 0xED bit pattern.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then shifts
// one byte plus odd parity out on the device-generated clock and waits for the ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int RTS_CYCLES     = 250,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_dat_drive_low,
    output logic       done,
    output logic       error,
    output logic       busy
);

    localparam int DLY_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int DW      = $clog2(DLY_MAX + 1);
    localparam int WW      = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DW-1:0] INH_LAST = DW'(INHIBIT_CYCLES - 1);
    localparam logic [DW-1:0] RTS_LAST = DW'(RTS_CYCLES - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        state;
    logic [DW-1:0] dly_cnt;
    logic [WW-1:0] wdog;
    logic [3:0]    bit_idx;
    logic [8:0]    shreg;

    logic [1:0] clk_sync;
    logic [1:0] dat_sync;
    logic       clk_prev;
    logic       clk_s;
    logic       dat_s;
    logic       fe;

    // Synchronisers reset to the idle-high bus level so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_dat_in};
            clk_prev <= clk_sync[1];
        end
    end

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];
    assign fe    = clk_prev & ~clk_s;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state             <= S_IDLE;
            dly_cnt           <= '0;
            wdog              <= '0;
            bit_idx           <= '0;
            shreg             <= '0;
            ps2_clk_drive_low <= 1'b0;
            ps2_dat_drive_low <= 1'b0;
            tx_ready          <= 1'b1;
            busy              <= 1'b0;
            done              <= 1'b0;
            error             <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                S_IDLE: begin
                    // tx_ready is held low for the first IDLE cycle after a pulse.
                    if (tx_ready && tx_valid) begin
                        shreg             <= {~^tx_data, tx_data};
                        dly_cnt           <= '0;
                        ps2_clk_drive_low <= 1'b1;
                        tx_ready          <= 1'b0;
                        busy              <= 1'b1;
                        state             <= S_INHIBIT;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end
                S_INHIBIT: begin
                    if (dly_cnt == INH_LAST) begin
                        dly_cnt           <= '0;
                        ps2_dat_drive_low <= 1'b1;
                        state             <= S_RTS;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                S_RTS: begin
                    if (dly_cnt == RTS_LAST) begin
                        dly_cnt           <= '0;
                        ps2_clk_drive_low <= 1'b0;
                        bit_idx           <= '0;
                        wdog              <= '0;
                        state             <= S_SEND;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                S_SEND: begin
                    if (fe) begin
                        wdog    <= '0;
                        bit_idx <= bit_idx + 4'd1;
                        if (bit_idx == 4'd9) begin
                            ps2_dat_drive_low <= 1'b0;
                            state             <= S_ACK;
                        end else begin
                            ps2_dat_drive_low <= ~shreg[0];
                            shreg             <= {1'b0, shreg[8:1]};
                        end
                    end else if (wdog == WD_LAST) begin
                        error             <= 1'b1;
                        ps2_clk_drive_low <= 1'b0;
                        ps2_dat_drive_low <= 1'b0;
                        busy              <= 1'b0;
                        state             <= S_IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                S_ACK: begin
                    if (fe) begin
                        wdog <= '0;
                        if (!dat_s) begin
                            state <= S_WAIT_IDLE;
                        end else begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end else if (wdog == WD_LAST) begin
                        error             <= 1'b1;
                        ps2_clk_drive_low <= 1'b0;
                        ps2_dat_drive_low <= 1'b0;
                        busy              <= 1'b0;
                        state             <= S_IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (clk_s && dat_s) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (wdog == WD_LAST) begin
                        error             <= 1'b1;
                        ps2_clk_drive_low <= 1'b0;
                        ps2_dat_drive_low <= 1'b0;
                        busy              <= 1'b0;
                        state             <= S_IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: begin
                    ps2_clk_drive_low <= 1'b0;
                    ps2_dat_drive_low <= 1'b0;
                    busy              <= 1'b0;
                    state             <= S_IDLE;
                end
            endcase
        end
    end

endmodule
